// File: rtl/alu_buffered_pkg.sv
// Shared opcode / funct3 encodings for the integer execution path.
// Reused by the decoder, the RS and the ALU.
package alu_buffered_pkg;

  localparam int ROB_POS_W_DEF = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    F3_ADD  = 3'd0,
    F3_SLL  = 3'd1,
    F3_SLT  = 3'd2,
    F3_SLTU = 3'd3,
    F3_XOR  = 3'd4,
    F3_SR   = 3'd5,
    F3_OR   = 3'd6,
    F3_AND  = 3'd7
  } alu_f3_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd4,
    BR_GE  = 3'd5,
    BR_LTU = 3'd6,
    BR_GEU = 3'd7
  } br_f3_e;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I/RV64I integer datapath: rd value, taken flag and next PC.
module alu_core
  import alu_buffered_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] val,
  output logic            jump,
  output logic [XLEN-1:0] next_pc
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] op_b, arith, pc_seq, pc_tgt;
  logic [SHW-1:0]  shamt;
  logic            cond;

  assign op_b   = (opcode == OPC_OP) ? val2 : imm;
  assign shamt  = op_b[SHW-1:0];
  assign pc_seq = pc + XLEN'(4);
  assign pc_tgt = pc + imm;

  always_comb begin
    arith = '0;
    case (funct3)
      F3_ADD:  arith = (opcode == OPC_OP && funct7) ? val1 - op_b : val1 + op_b;
      F3_SLL:  arith = val1 << shamt;
      F3_SLT:  arith = XLEN'($signed(val1) < $signed(op_b));
      F3_SLTU: arith = XLEN'(val1 < op_b);
      F3_XOR:  arith = val1 ^ op_b;
      F3_SR:   arith = funct7 ? XLEN'($signed(val1) >>> shamt) : val1 >> shamt;
      F3_OR:   arith = val1 | op_b;
      F3_AND:  arith = val1 & op_b;
      default: arith = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (funct3)
      BR_EQ:   cond = (val1 == val2);
      BR_NE:   cond = (val1 != val2);
      BR_LT:   cond = ($signed(val1) <  $signed(val2));
      BR_GE:   cond = ($signed(val1) >= $signed(val2));
      BR_LTU:  cond = (val1 <  val2);
      BR_GEU:  cond = (val1 >= val2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    val     = '0;
    jump    = 1'b0;
    next_pc = pc_seq;
    case (opcode)
      OPC_OP, OPC_OPIMM: val = arith;
      OPC_LUI:           val = imm;
      OPC_AUIPC:         val = pc_tgt;
      OPC_JAL: begin
        val     = pc_seq;
        jump    = 1'b1;
        next_pc = pc_tgt;
      end
      OPC_JALR: begin
        val     = pc_seq;
        jump    = 1'b1;
        next_pc = (val1 + imm) & ~XLEN'(1);
      end
      OPC_BRANCH: begin
        jump    = cond;
        next_pc = cond ? pc_tgt : pc_seq;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_buffered.sv
// Integer execution unit: computes at dispatch and queues results in a small
// in-order FIFO until the CDB grants a broadcast. Flushed by rollback.
module alu_buffered
  import alu_buffered_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_POS_W = ROB_POS_W_DEF,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_en,
  output logic                 alu_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic [XLEN-1:0]      val1,
  input  logic [XLEN-1:0]      val2,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      pc,
  input  logic [ROB_POS_W-1:0] rob_pos,
  output logic                 result,
  input  logic                 result_ack,
  output logic [ROB_POS_W-1:0] result_rob_pos,
  output logic [XLEN-1:0]      result_val,
  output logic                 result_jump,
  output logic [XLEN-1:0]      result_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] core_val, core_pc;
  logic            core_jump;

  alu_core #(.XLEN(XLEN)) u_core (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .val1    (val1),
    .val2    (val2),
    .imm     (imm),
    .pc      (pc),
    .val     (core_val),
    .jump    (core_jump),
    .next_pc (core_pc)
  );

  logic [ROB_POS_W-1:0] rob_q  [DEPTH];
  logic [XLEN-1:0]      val_q  [DEPTH];
  logic                 jump_q [DEPTH];
  logic [XLEN-1:0]      pc_q   [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready comes only from the registered count, so a grant never reaches the RS
  // combinationally; DEPTH=1 therefore alternates accept/drain.
  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign alu_ready = ~full;
  assign push      = alu_en & ~full & rdy & ~rollback;
  assign pop       = ~empty & result_ack & rdy & ~rollback;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (rdy) begin
      if (rollback) begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
      end else begin
        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + CW'(1);
          2'b01:   cnt_d = cnt_q - CW'(1);
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      rob_q[wptr_q]  <= rob_pos;
      val_q[wptr_q]  <= core_val;
      jump_q[wptr_q] <= core_jump;
      pc_q[wptr_q]   <= core_pc;
    end
  end

  assign result         = ~empty;
  assign result_rob_pos = empty ? '0   : rob_q[rptr_q];
  assign result_val     = empty ? '0   : val_q[rptr_q];
  assign result_jump    = empty ? 1'b0 : jump_q[rptr_q];
  assign result_pc      = empty ? '0   : pc_q[rptr_q];

endmodule

// File: tb/tb_alu_buffered.sv
// Directed bench for alu_buffered (XLEN=32, DEPTH=2) with hand-computed results.
module tb_alu_buffered;

  localparam int XLEN = 32;
  localparam int RW   = 4;

  localparam logic [6:0] OP  = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011, BAD = 7'b0000000;

  logic            clk = 1'b0;
  logic            rst_n, rdy, rollback, alu_en, alu_ready, funct7;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] val1, val2, imm, pc;
  logic [RW-1:0]   rob_pos, result_rob_pos;
  logic            result, result_ack, result_jump;
  logic [XLEN-1:0] result_val, result_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_buffered #(.XLEN(XLEN), .ROB_POS_W(RW), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .alu_en(alu_en), .alu_ready(alu_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .val1(val1), .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos),
    .result(result), .result_ack(result_ack), .result_rob_pos(result_rob_pos),
    .result_val(result_val), .result_jump(result_jump), .result_pc(result_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] p, input logic [3:0] rp);
    opcode = op; funct3 = f3; funct7 = f7;
    val1 = a; val2 = b; imm = im; pc = p; rob_pos = rp;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] p, input logic [3:0] rp);
    set_op(op, f3, f7, a, b, im, p, rp);
    alu_en = 1'b1;
    tick();
    alu_en = 1'b0;
    set_op(BAD, 3'd0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF);
  endtask

  task automatic head(input string tag, input logic [3:0] rp, input logic [31:0] v,
                      input logic j, input logic [31:0] npc);
    chk({tag, ".valid"}, 64'(result), 64'd1);
    chk({tag, ".rob"},   64'(result_rob_pos), 64'(rp));
    chk({tag, ".val"},   64'(result_val), 64'(v));
    chk({tag, ".jump"},  64'(result_jump), 64'(j));
    chk({tag, ".pc"},    64'(result_pc), 64'(npc));
  endtask

  task automatic pop();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic one(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] im, input logic [31:0] p, input logic [3:0] rp,
                     input logic [31:0] v, input logic j, input logic [31:0] npc);
    issue(op, f3, f7, a, b, im, p, rp);
    head(tag, rp, v, j, npc);
    pop();
    chk({tag, ".drained"}, 64'(result), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0; result_ack = 1'b0;
    set_op(BAD, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    #1;
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.ready",  64'(alu_ready), 64'd1);
    chk("rst.rob",    64'(result_rob_pos), 64'd0);
    chk("rst.val",    64'(result_val), 64'd0);
    chk("rst.jump",   64'(result_jump), 64'd0);
    chk("rst.pc",     64'(result_pc), 64'd0);
    #11 rst_n = 1'b1;
    tick();

    // Arithmetic, compares, shifts
    one("add",  OP,  3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h100, 4'd1, 32'd12, 1'b0, 32'h104);
    one("sub",  OP,  3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'h100, 4'd2, 32'hFFFF_FFFE, 1'b0, 32'h104);
    one("addi", OPI, 3'd0, 1'b1, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3, 32'd12, 1'b0, 32'h104);
    one("slt",  OP,  3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 4'd4, 32'd1, 1'b0, 32'h4);
    one("sltu", OP,  3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 4'd5, 32'd0, 1'b0, 32'h4);
    one("srai", OPI, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h0, 4'd6, 32'hF800_0000, 1'b0, 32'h4);
    one("srli", OPI, 3'd5, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 32'h0, 4'd7, 32'h0800_0000, 1'b0, 32'h4);
    one("sll",  OP,  3'd1, 1'b0, 32'h1, 32'h21, 32'd0, 32'h0, 4'd8, 32'h2, 1'b0, 32'h4);
    one("lui",  LUI, 3'd0, 1'b0, 32'd9, 32'd9, 32'h1234_5000, 32'h40, 4'd9, 32'h1234_5000, 1'b0, 32'h44);
    one("auipc",AUI, 3'd0, 1'b0, 32'd9, 32'd9, 32'h1000, 32'h40, 4'd10, 32'h1040, 1'b0, 32'h44);
    // Control transfer
    one("bne",  BR,  3'd1, 1'b0, 32'd3, 32'd3, 32'h20, 32'h100, 4'd11, 32'd0, 1'b0, 32'h104);
    one("blt",  BR,  3'd4, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd12, 32'd0, 1'b1, 32'h120);
    one("bltu", BR,  3'd6, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd13, 32'd0, 1'b0, 32'h104);
    one("jalr", JALR,3'd0, 1'b0, 32'h203, 32'd0, 32'd0, 32'h100, 4'd14, 32'h104, 1'b1, 32'h202);
    one("jal",  JAL, 3'd0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h100, 4'd15, 32'h104, 1'b1, 32'hF0);
    one("bad",  BAD, 3'd0, 1'b0, 32'd5, 32'd7, 32'd1, 32'h200, 4'd0, 32'd0, 1'b0, 32'h204);

    // Back-pressure: three back-to-back with no ack
    set_op(OP, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
    alu_en = 1'b1;
    tick();
    chk("bp.ready1", 64'(alu_ready), 64'd1);
    rob_pos = 4'd2;
    tick();
    chk("bp.ready2", 64'(alu_ready), 64'd0);
    rob_pos = 4'd3;
    tick();
    chk("bp.held.ready", 64'(alu_ready), 64'd0);
    chk("bp.held.head",  64'(result_rob_pos), 64'd1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("bp.ack.ready", 64'(alu_ready), 64'd1);
    chk("bp.ack.head",  64'(result_rob_pos), 64'd2);
    tick();
    alu_en = 1'b0;
    chk("bp.third.ready", 64'(alu_ready), 64'd0);
    head("bp.q2", 4'd2, 32'd2, 1'b0, 32'h4);
    pop();
    head("bp.q3", 4'd3, 32'd2, 1'b0, 32'h4);
    pop();
    chk("bp.drained", 64'(result), 64'd0);

    // Rollback with two queued and simultaneous push/ack
    issue(OP, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd4);
    issue(OP, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h0, 4'd5);
    set_op(OP, 3'd0, 1'b0, 32'd8, 32'd8, 32'd0, 32'h0, 4'd6);
    alu_en = 1'b1; result_ack = 1'b1; rollback = 1'b1;
    tick();
    alu_en = 1'b0; result_ack = 1'b0; rollback = 1'b0;
    chk("rb.result", 64'(result), 64'd0);
    chk("rb.ready",  64'(alu_ready), 64'd1);
    chk("rb.rob",    64'(result_rob_pos), 64'd0);
    issue(OP, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'h10, 4'd7);
    head("rb.next", 4'd7, 32'd3, 1'b0, 32'h14);

    // rdy=0 freezes everything despite ack and alu_en
    set_op(OP, 3'd0, 1'b0, 32'd10, 32'd20, 32'd0, 32'h20, 4'd8);
    rdy = 1'b0; result_ack = 1'b1; alu_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      head("frz", 4'd7, 32'd3, 1'b0, 32'h14);
      chk("frz.ready", 64'(alu_ready), 64'd1);
    end
    rdy = 1'b1;
    tick();
    result_ack = 1'b0; alu_en = 1'b0;
    head("pushpop", 4'd8, 32'd30, 1'b0, 32'h24);
    issue(OP, 3'd0, 1'b0, 32'd4, 32'd4, 32'd0, 32'h30, 4'd9);
    chk("pre_rst.ready", 64'(alu_ready), 64'd0);

    // Async reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst.result", 64'(result), 64'd0);
    chk("arst.ready",  64'(alu_ready), 64'd1);
    chk("arst.rob",    64'(result_rob_pos), 64'd0);
    chk("arst.val",    64'(result_val), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("arst.after", 64'(result), 64'd0);
    one("post", OP, 3'd7, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'h0, 4'd10, 32'h00F0, 1'b0, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
